// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Architectural integer register file (r0 hardwired to zero) with a
//   per-register pending-writer scoreboard.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     wb_we/wb_idx/wb_data         writeback register write port
//     rs1_idx/rs2_idx              decode operand read indices
//     rs1_data/rs2_data            operands, bypassed from same-cycle writeback
//     rs1_busy/rs2_busy            operand still has an uncommitted writer
//     iss_valid/iss_wr/iss_rd      decode issue request (iss_rd is the destination)
//     iss_rdy                      destination counter has room for another writer
//     flush                        drop all pending counts
//     sb_err                       sticky: writeback hit a register with no pending writer
module regfile_scoreboard #(
  parameter int NR_REG = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [4:0]        wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        rs1_idx,
  input  logic [4:0]        rs2_idx,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [4:0]        iss_rd,
  output logic              iss_rdy,
  input  logic              flush,
  output logic              sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NR_REG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NR_REG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                          sb_err_q, sb_err_d;

  logic              wb_hit, dec, inc;
  logic [NR_REG-1:0] inc_v, dec_v, ovf_v;

  // Operand read: r0 is zero, a same-cycle writeback is forwarded.
  // Busy is dropped when the writer committing right now is the last one.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_idx != 5'd0) rs1_data = (wb_we && wb_idx == rs1_idx) ? wb_data : regs_q[rs1_idx];
    if (rs2_idx != 5'd0) rs2_data = (wb_we && wb_idx == rs2_idx) ? wb_data : regs_q[rs2_idx];
    rs1_busy = (rs1_idx != 5'd0) && (cnt_q[rs1_idx] != '0) &&
               !(wb_we && wb_idx == rs1_idx && cnt_q[rs1_idx] == CNT_ONE);
    rs2_busy = (rs2_idx != 5'd0) && (cnt_q[rs2_idx] != '0) &&
               !(wb_we && wb_idx == rs2_idx && cnt_q[rs2_idx] == CNT_ONE);
  end

  // A commit to a full counter frees a slot in the same cycle, so an
  // issue to that register is still accepted.
  always_comb begin
    wb_hit  = wb_we && (wb_idx != 5'd0);
    dec     = wb_hit && (cnt_q[wb_idx] != '0);
    iss_rdy = !(iss_wr && (iss_rd != 5'd0) && (cnt_q[iss_rd] == CNT_MAX) &&
                !(dec && wb_idx == iss_rd));
    inc     = iss_valid && iss_rdy && iss_wr && (iss_rd != 5'd0) && !flush;
  end

  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    inc_v    = '0;
    dec_v    = '0;
    ovf_v    = '0;
    sb_err_d = sb_err_q | (wb_hit && cnt_q[wb_idx] == '0 && !flush);
    // Data is written even in flush cycles and on an sb_err commit.
    if (wb_hit) regs_d[wb_idx] = wb_data;
    for (int r = 0; r < NR_REG; r++) begin
      inc_v[r] = inc && (iss_rd == 5'(r));
      dec_v[r] = dec && (wb_idx == 5'(r));
      ovf_v[r] = inc_v[r] && !dec_v[r] && (cnt_q[r] == CNT_MAX);
      if (flush)                      cnt_d[r] = '0;
      else if (inc_v[r] && !dec_v[r]) cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec_v[r] && !inc_v[r]) cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // iss_rdy must keep every counter from wrapping.
  always_ff @(posedge clk) begin
    if (!rst) assert (ovf_v == '0);
  end

  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst, wb_we, iss_valid, iss_wr, flush;
  logic [4:0]  wb_idx, rs1_idx, rs2_idx, iss_rd;
  logic [31:0] wb_data, rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, iss_rdy, sb_err;

  regfile_scoreboard #(.NR_REG(32), .DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .iss_valid(iss_valid), .iss_wr(iss_wr),
    .iss_rd(iss_rd), .iss_rdy(iss_rdy), .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, we; bit [4:0] wi; bit [31:0] wd;
    bit [4:0] i1, i2; bit iv, iw; bit [4:0] rd; bit fl;
  } in_t;
  typedef struct { bit [31:0] d1, d2; bit b1, b2, rdy, err; } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  bit   done = 0;

  // Reference model: register contents, number of writers in flight, error flag.
  bit [31:0] mem[32];
  int        pend[32];
  bit        err;
  localparam int MAXPEND = 3;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic bit [31:0] m_read(input bit [4:0] i, input in_t t);
    if (i == 0) return 0;
    if (t.we && t.wi == i) return t.wd;
    return mem[i];
  endfunction

  function automatic bit m_busy(input bit [4:0] i, input in_t t);
    if (i == 0 || pend[i] == 0) return 0;
    return !(t.we && t.wi == i && pend[i] == 1);
  endfunction

  // One clock: apply inputs, queue the expected response, advance the model.
  task automatic step(input in_t t);
    exp_t e;
    bit commit, issue;
    @(posedge clk); #1;
    rst = t.rst; wb_we = t.we; wb_idx = t.wi; wb_data = t.wd;
    rs1_idx = t.i1; rs2_idx = t.i2; iss_valid = t.iv; iss_wr = t.iw;
    iss_rd = t.rd; flush = t.fl;
    commit = t.we && t.wi != 0 && pend[t.wi] > 0;
    e.d1  = m_read(t.i1, t);
    e.d2  = m_read(t.i2, t);
    e.b1  = m_busy(t.i1, t);
    e.b2  = m_busy(t.i2, t);
    e.rdy = !(t.iw && t.rd != 0 && pend[t.rd] == MAXPEND && !(commit && t.wi == t.rd));
    e.err = err;
    exp_q.push_back(e);
    issue = t.iv && e.rdy && t.iw && t.rd != 0 && !t.fl;
    if (t.rst) begin
      foreach (mem[k]) begin mem[k] = 0; pend[k] = 0; end
      err = 0;
    end else begin
      if (t.we && t.wi != 0 && pend[t.wi] == 0 && !t.fl) err = 1;
      if (t.we && t.wi != 0) mem[t.wi] = t.wd;
      if (t.fl) foreach (pend[k]) pend[k] = 0;
      else begin
        if (commit) pend[t.wi]--;
        if (issue)  pend[t.rd]++;
      end
    end
    @(negedge clk); #1;
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rs1_data", rs1_data, e.d1);
        chk("rs2_data", rs2_data, e.d2);
        chk("rs1_busy", 32'(rs1_busy), 32'(e.b1));
        chk("rs2_busy", 32'(rs2_busy), 32'(e.b2));
        chk("iss_rdy",  32'(iss_rdy),  32'(e.rdy));
        chk("sb_err",   32'(sb_err),   32'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    in_t t;
    int  cand[$];
    rst = 1; wb_we = 0; wb_idx = 0; wb_data = 0; rs1_idx = 0; rs2_idx = 0;
    iss_valid = 0; iss_wr = 0; iss_rd = 0; flush = 0;
    repeat (2) @(posedge clk);
    foreach (mem[k]) begin mem[k] = 0; pend[k] = 0; end
    err = 0;

    // reset state
    t = '{default: 0}; t.i1 = 1; t.i2 = 2; step(t);
    chk("rst_data", rs1_data, 0); chk("rst_busy", 32'(rs1_busy), 0);
    chk("rst_rdy", 32'(iss_rdy), 1); chk("rst_err", 32'(sb_err), 0);

    // issue r5, see busy, commit with bypass
    t = '{default: 0}; t.iv = 1; t.iw = 1; t.rd = 5; step(t);
    t = '{default: 0}; t.i1 = 5; step(t);
    chk("busy_r5", 32'(rs1_busy), 1);
    t.we = 1; t.wi = 5; t.wd = 32'hDEADBEEF; step(t);
    chk("byp_busy", 32'(rs1_busy), 0); chk("byp_data", rs1_data, 32'hDEADBEEF);
    t = '{default: 0}; t.i1 = 5; step(t);
    chk("arr_data", rs1_data, 32'hDEADBEEF); chk("arr_busy", 32'(rs1_busy), 0);

    // saturate r7
    t = '{default: 0}; t.iv = 1; t.iw = 1; t.rd = 7;
    repeat (3) step(t);
    t.iv = 0; step(t); chk("full_rdy7", 32'(iss_rdy), 0);
    t.rd = 8; step(t); chk("rdy8", 32'(iss_rdy), 1);
    t.iv = 1; t.rd = 7; t.we = 1; t.wi = 7; t.wd = 32'h77; step(t);
    chk("retire_rdy7", 32'(iss_rdy), 1);
    t = '{default: 0}; t.iw = 1; t.rd = 7; t.i1 = 7; step(t);
    chk("still_full7", 32'(iss_rdy), 0); chk("busy7", 32'(rs1_busy), 1);

    // issue dropped by flush
    t = '{default: 0}; t.iv = 1; t.iw = 1; t.rd = 3; t.fl = 1; t.i1 = 3; step(t);
    t = '{default: 0}; t.i1 = 3; t.i2 = 7; step(t);
    chk("flush_b3", 32'(rs1_busy), 0); chk("flush_b7", 32'(rs2_busy), 0);

    // r0
    t = '{default: 0}; t.we = 1; t.wi = 0; t.wd = 32'h12345678;
    t.iv = 1; t.iw = 1; t.rd = 0; step(t);
    chk("r0_byp", rs1_data, 0); chk("r0_rdy", 32'(iss_rdy), 1);
    t = '{default: 0}; step(t);
    chk("r0_data", rs1_data, 0); chk("r0_busy", 32'(rs1_busy), 0);

    // orphan writeback, then mid-run reset
    t = '{default: 0}; t.iv = 1; t.iw = 1; t.rd = 4; step(t);
    t = '{default: 0}; t.we = 1; t.wi = 9; t.wd = 32'h0000A5A5; step(t);
    t = '{default: 0}; t.i1 = 9; t.i2 = 4; step(t);
    chk("orph_data", rs1_data, 32'h0000A5A5); chk("orph_err", 32'(sb_err), 1);
    step(t); chk("err_sticky", 32'(sb_err), 1);
    t.rst = 1; step(t);
    t.rst = 0; step(t);
    chk("rst2_data", rs1_data, 0); chk("rst2_err", 32'(sb_err), 0);
    chk("rst2_busy", 32'(rs2_busy), 0);

    // random traffic, indices biased to a few registers for hazards
    for (int n = 0; n < 4000; n++) begin
      t = '{default: 0};
      t.rst = ($urandom_range(0, 599) == 0);
      t.fl  = ($urandom_range(0, 39) == 0);
      t.we  = $urandom_range(0, 1);
      cand.delete();
      for (int k = 1; k < 32; k++) if (pend[k] > 0) cand.push_back(k);
      if (cand.size() != 0 && $urandom_range(0, 9) < 8)
        t.wi = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        t.wi = 5'($urandom_range(0, 7));
      t.wd = $urandom;
      t.i1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      t.i2 = 5'($urandom_range(0, 7));
      t.iv = $urandom_range(0, 1);
      t.iw = ($urandom_range(0, 3) != 0);
      t.rd = 5'($urandom_range(0, 7));
      step(t);
    end

    @(posedge clk); #1;
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural integer register file plus pending-write scoreboard.
- Sits at the receiving end of the writeback stage's register write port (reg_idx/reg_we/reg_data).
- Serves decode with bypassed operand reads and RAW-hazard busy flags.
- Tracks in-flight writers per register: decode increments a register's count on issue, writeback decrements it on commit, and a pipeline flush clears all counts.

Parameters:
NR_REG, 32, number of architectural registers (r0 hardwired to zero)
DATA_W, 32, register width
CNT_W, 2, per-register pending counter width (max in-flight writers = 2^CNT_W-1 = 3)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
wb_we  input  1  writeback write enable (writeback reg_we)
wb_idx  input  5  writeback destination index
wb_data  input  DATA_W  writeback data
rs1_idx  input  5  decode source 1 index
rs2_idx  input  5  decode source 2 index
rs1_data  output  DATA_W  source 1 operand (combinational)
rs2_data  output  DATA_W  source 2 operand (combinational)
rs1_busy  output  1  source 1 has an uncommitted writer
rs2_busy  output  1  source 2 has an uncommitted writer
iss_valid  input  1  decode presents an instruction for issue
iss_wr  input  1  issuing instruction writes rd
iss_rd  input  5  issuing instruction destination
iss_rdy  output  1  scoreboard can accept the issue
flush  input  1  pipeline flush; clears all pending counts
sb_err  output  1  sticky error: writeback to a register with zero pending count

Behaviour:
- Reset (rst=1 at posedge): all registers become 0, all counters become 0, sb_err becomes 0. Outputs after reset: rs*_data=0, rs*_busy=0, iss_rdy=1.
- Writes: on posedge, if wb_we and wb_idx!=0, then reg[wb_idx] <= wb_data. Writes to r0 are dropped. Writes always occur, including in flush cycles.
- Reads: rsN_data = 0 if rsN_idx==0. Otherwise, if wb_we and wb_idx==rsN_idx, rsN_data = wb_data (same-cycle bypass). Otherwise rsN_data = reg[rsN_idx].
- Busy:
  - rsN_busy = (rsN_idx!=0) & (cnt[rsN_idx]!=0).
  - Exception: rsN_busy is forced low when wb_we, wb_idx==rsN_idx and cnt==1, because the last writer commits this cycle and its data is bypassed.
  - Busy is computed from current counters only; the same-cycle issue does not affect it.
- Define dec = wb_we & wb_idx!=0 & cnt[wb_idx]!=0.
- Issue ready: iss_rdy=0 iff iss_wr & iss_rd!=0 & cnt[iss_rd]==MAX & ~(dec & wb_idx==iss_rd). iss_rdy does not depend on iss_valid.
- Define inc = iss_valid & iss_rdy & iss_wr & iss_rd!=0 & ~flush.
- Counter update per register r, in priority order:
  - flush: cnt <= 0.
  - inc & dec both targeting r: unchanged.
  - inc only: +1.
  - dec only: -1.
  - Otherwise unchanged.
- A flush that coincides with an issue drops the issue; decode must re-present it.
- Error: wb_we & wb_idx!=0 & cnt[wb_idx]==0 & ~flush sets sb_err, which stays set until rst. The data is still written and the counter stays at 0 (no underflow).
- Counters never wrap: saturation is prevented by iss_rdy; an overflow is unreachable by construction and must be asserted against in simulation.
- Flush precondition: writeback must not commit any instruction older than the flush after the flush cycle.

Test Plan:
- Reset, then read r1/r2 -> data 0, busy 0, iss_rdy=1, sb_err=0.
- Issue rd=5; next cycle rs1_idx=5 -> rs1_busy=1. Then wb_we, wb_idx=5, wb_data=0xDEADBEEF -> same cycle rs1_busy=0, rs1_data=0xDEADBEEF; next cycle array holds 0xDEADBEEF.
- Three issues to rd=7 -> iss_rdy=0 for rd=7 and 1 for rd=8. Retire one rd=7 writeback while issuing rd=7 -> iss_rdy=1, count stays 3.
- Issue rd=3 with flush=1 in the same cycle -> cnt[3]=0, rs busy on 3 never asserts.
- Write r0 with 0x12345678; issue rd=0 -> r0 reads 0, never busy, iss_rdy=1.
- wb_we to rd=9 with cnt[9]=0 -> reg[9] updated, sb_err=1 and stays set until rst; a mid-operation rst clears all counters, registers and sb_err.
